// File: rtl/alu_exec_stage_if.sv
// alu_exec_stage_if: handshake/operand bundle for the execute-stage ALU.
//   Upstream side : in_valid, in_ready, alu_func, jr_in, op_a, op_b, shamt
//   Downstream side: out_valid, out_ready, result, zero, jr_out
//                    (+ ovf when ALU_OVF_DETECT_EN is defined)
//   master modport : the environment (drives operations, accepts results)
//   slave modport  : the ALU stage itself
interface alu_exec_stage_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_func;
  logic             jr_in;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       shamt;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             jr_out;
`ifdef ALU_OVF_DETECT_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, alu_func, jr_in, op_a, op_b, shamt, out_ready,
    input  in_ready, out_valid, result, zero, jr_out
`ifdef ALU_OVF_DETECT_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, alu_func, jr_in, op_a, op_b, shamt, out_ready,
    output in_ready, out_valid, result, zero, jr_out
`ifdef ALU_OVF_DETECT_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with a registered result.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   bus        : alu_exec_stage_if.slave (operation in, result out, valid/ready)
// Most function codes complete in one cycle; SLL/SRA/SRL with shamt>0 run an
// iterative 1-bit-per-cycle shifter and hold in_ready low meanwhile.
// Optional macro ALU_OVF_DETECT_EN adds a registered signed-overflow flag (ovf)
// for ADD/SUB.
module alu_exec_stage #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned LUI_SHIFT = 16
) (
  input  logic             clk,
  input  logic             reset,
  alu_exec_stage_if.slave  bus
);

  localparam logic [3:0] F_AND  = 4'b0000;
  localparam logic [3:0] F_OR   = 4'b0001;
  localparam logic [3:0] F_ADD  = 4'b0010;
  localparam logic [3:0] F_SUB  = 4'b0110;
  localparam logic [3:0] F_SLT  = 4'b0111;
  localparam logic [3:0] F_SLTU = 4'b1110;
  localparam logic [3:0] F_XOR  = 4'b1001;
  localparam logic [3:0] F_SLL  = 4'b1010;
  localparam logic [3:0] F_SRA  = 4'b1011;
  localparam logic [3:0] F_SRL  = 4'b1100;
  localparam logic [3:0] F_LUI  = 4'b1101;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] work, work_nx;
  logic [4:0]       count;
  logic [3:0]       func_q;
  logic             jr_q;

  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             jr_out_q;
  logic             ovf_q;

  logic             in_ready_c;
  logic             accept;
  logic             is_shift;
  logic             start_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic [WIDTH-1:0] sum, diff;

  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             load_jr;
  logic             load_ovf;

  assign is_shift    = (bus.alu_func == F_SLL) || (bus.alu_func == F_SRA) ||
                       (bus.alu_func == F_SRL);
  assign accept      = bus.in_valid && in_ready_c;
  assign start_shift = accept && is_shift && (bus.shamt != 5'd0);

  assign sum  = bus.op_a + bus.op_b;
  assign diff = bus.op_a - bus.op_b;

  // Single-cycle result; a shift with shamt==0 simply passes op_b through.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    unique case (bus.alu_func)
      F_AND:  alu_res = bus.op_a & bus.op_b;
      F_OR:   alu_res = bus.op_a | bus.op_b;
      F_XOR:  alu_res = bus.op_a ^ bus.op_b;
      F_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.op_a[WIDTH-1] == bus.op_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      F_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.op_a[WIDTH-1] != bus.op_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != bus.op_a[WIDTH-1]);
      end
      F_SLT:  alu_res = WIDTH'($signed(bus.op_a) < $signed(bus.op_b));
      F_SLTU: alu_res = WIDTH'(bus.op_a < bus.op_b);
      F_SLL, F_SRA, F_SRL: alu_res = bus.op_b;
      F_LUI:  alu_res = bus.op_b << LUI_SHIFT;
      default: alu_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter.
  always_comb begin
    work_nx = work;
    unique case (func_q)
      F_SLL:   work_nx = {work[WIDTH-2:0], 1'b0};
      F_SRA:   work_nx = {work[WIDTH-1], work[WIDTH-1:1]};
      default: work_nx = {1'b0, work[WIDTH-1:1]};
    endcase
  end

  // FSM next state and handshake output.
  always_comb begin
    state_n    = state;
    in_ready_c = (state == IDLE) && (!out_valid_q || bus.out_ready) && !reset;
    unique case (state)
      IDLE:  if (start_shift) state_n = SHIFT;
      SHIFT: if (count == 5'd1) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Result-register load source: either a single-cycle op accepted in IDLE or
  // the final step of the iterative shifter.
  always_comb begin
    load     = 1'b0;
    load_val = alu_res;
    load_jr  = bus.jr_in;
    load_ovf = alu_ovf;
    if (state == SHIFT) begin
      load     = (count == 5'd1);
      load_val = work_nx;
      load_jr  = jr_q;
      load_ovf = 1'b0;
    end else if (accept && !start_shift) begin
      load = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      work        <= '0;
      count       <= '0;
      func_q      <= '0;
      jr_q        <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      jr_out_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state <= state_n;
      if (start_shift) begin
        work   <= bus.op_b;
        count  <= bus.shamt;
        func_q <= bus.alu_func;
        jr_q   <= bus.jr_in;
      end else if (state == SHIFT) begin
        work  <= work_nx;
        count <= count - 5'd1;
      end
      if (load) begin
        result_q <= load_val;
        zero_q   <= (load_val == '0);
        jr_out_q <= load_jr;
        ovf_q    <= load_ovf;
      end
      // A drain and a new load at the same edge keep out_valid high.
      if (load)
        out_valid_q <= 1'b1;
      else if (out_valid_q && bus.out_ready)
        out_valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.jr_out    = jr_out_q;
`ifdef ALU_OVF_DETECT_EN
  assign bus.ovf       = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule
